// File: rtl/md_sequencer.sv
// Multiply/divide sequencer owning HI/LO: results commit after MUL_CYCLES/DIV_CYCLES busy cycles, MTHI/MTLO update next edge.
// busy is registered; start during RUN is dropped (hazard unit stalls). Define MD_SEQ_MADD_EN to decode MADD/MADDU.
module md_sequencer #(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  mdop,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MD_SEQ_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
`endif
  localparam logic [3:0] MUL_LD = 4'(MUL_CYCLES - 1);
  localparam logic [3:0] DIV_LD = 4'(DIV_CYCLES - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state, state_d;
  logic [3:0]  cnt, cnt_d;
  logic [31:0] hi_n, lo_n, hi_n_d, lo_n_d, hi_d, lo_d;
  logic [63:0] sprod, uprod;
  logic [31:0] sq, sr, uq, ur;

  assign sprod = {{32{A[31]}}, A} * {{32{B[31]}}, B};
  assign uprod = {32'b0, A} * {32'b0, B};
  assign busy  = (state == RUN);

  // The one signed overflow case is pinned explicitly rather than trusting the simulator's divide.
  always_comb begin
    sq = '0;
    sr = '0;
    uq = '0;
    ur = '0;
    if (A == 32'h8000_0000 && B == 32'hFFFF_FFFF) begin
      sq = 32'h8000_0000;
    end else if (B != 32'd0) begin
      sq = $signed(A) / $signed(B);
      sr = $signed(A) % $signed(B);
    end
    if (B != 32'd0) begin
      uq = A / B;
      ur = A % B;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    hi_n_d  = hi_n;
    lo_n_d  = lo_n;
    hi_d    = HI;
    lo_d    = LO;
    case (state)
      IDLE: begin
        if (start) begin
          case (mdop)
            OP_MULT: begin
              {hi_n_d, lo_n_d} = sprod;
              cnt_d   = MUL_LD;
              state_d = RUN;
            end
            OP_MULTU: begin
              {hi_n_d, lo_n_d} = uprod;
              cnt_d   = MUL_LD;
              state_d = RUN;
            end
            OP_DIV, OP_DIVU: begin
              // Divide by zero still burns the full window but recommits the current HI/LO.
              if (B == 32'd0) begin
                hi_n_d = HI;
                lo_n_d = LO;
              end else if (mdop == OP_DIV) begin
                hi_n_d = sr;
                lo_n_d = sq;
              end else begin
                hi_n_d = ur;
                lo_n_d = uq;
              end
              cnt_d   = DIV_LD;
              state_d = RUN;
            end
            OP_MTHI: hi_d = A;
            OP_MTLO: lo_d = A;
`ifdef MD_SEQ_MADD_EN
            OP_MADD: begin
              {hi_n_d, lo_n_d} = {HI, LO} + sprod;
              cnt_d   = MUL_LD;
              state_d = RUN;
            end
            OP_MADDU: begin
              {hi_n_d, lo_n_d} = {HI, LO} + uprod;
              cnt_d   = MUL_LD;
              state_d = RUN;
            end
`endif
            default: ;
          endcase
        end
      end
      RUN: begin
        if (cnt == 4'd0) begin
          hi_d    = hi_n;
          lo_d    = lo_n;
          state_d = IDLE;
        end else begin
          cnt_d = cnt - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
      hi_n  <= 32'd0;
      lo_n  <= 32'd0;
      HI    <= 32'd0;
      LO    <= 32'd0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      hi_n  <= hi_n_d;
      lo_n  <= lo_n_d;
      HI    <= hi_d;
      LO    <= lo_d;
    end
  end

endmodule

// File: doc/md_sequencer.md
# md_sequencer

Multiply/divide sequencer for the E-stage datapath, beside the ALU. Accepts one multiply, divide or HI/LO-move operation per start pulse, models the fixed multi-cycle latency of the multiplier and divider, and owns the HI and LO architectural registers. It raises `busy` so the hazard unit can stall later multiply/divide-class instructions in D. Results commit atomically to HI/LO at the end of the latency window.

## Interface
- `MUL_CYCLES`, 5: busy cycles for MULT/MULTU (and MADD/MADDU when compiled in); legal range 1..15.
- `DIV_CYCLES`, 10: busy cycles for DIV/DIVU; legal range 1..15.

- `clk`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high; clears all state on the next rising edge.
- `start`  in  1: operation request, valid one cycle, from the E stage.
- `mdop`  in  4: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MADD, 8 MADDU; 9–15 are NONE.
- `A`  in  32: rs operand (dividend / multiplicand / MTHI/MTLO source).
- `B`  in  32: rt operand (divisor / multiplier).
- `busy`  out  1: operation in flight.
- `HI`  out  32: registered HI; MFHI reads this.
- `LO`  out  32: registered LO; MFLO reads this.

## Operation
- FSM states: IDLE and RUN. 4-bit down-counter `cnt`; result staging registers `hi_n` and `lo_n`.
- IDLE, `start`=1, op MULT/MULTU/DIV/DIVU (MADD/MADDU when enabled):
  - Compute the result from A/B into `hi_n`/`lo_n`.
  - Load `cnt` with the op's cycle count, minus 1.
  - Go to RUN.
- RUN: decrement `cnt` each cycle. At `cnt`=0, write `hi_n`/`lo_n` to HI/LO and go to IDLE in the same edge.
- MTHI/MTLO in IDLE with `start`=1: HI←A or LO←A on that edge. No busy, no RUN.
- NONE or an undefined `mdop` with `start`=1: no effect.
- `start` while in RUN: ignored entirely, including MTHI/MTLO. The hazard unit must stall instead. In-flight op and HI/LO are unaffected.
- Arithmetic:
  - MULT: signed 32×32→64. MULTU: unsigned. {HI,LO}=product.
  - DIV: signed. LO=quotient, truncated toward zero. HI=remainder, sign of the dividend.
  - DIVU: unsigned.
  - 0x80000000 / 0xFFFFFFFF (DIV): LO=0x80000000, HI=0.
  - Divide by zero (B=0): full DIV_CYCLES busy window, then HI/LO unchanged. `hi_n`/`lo_n` are loaded with the current HI/LO.
  - MADD/MADDU: {HI,LO} ← {HI,LO} + signed/unsigned product, wrapping mod 2^64. The accumulator operand is HI/LO as sampled at the start edge.
- `reset`:
  - Takes priority over everything.
  - Next edge: state IDLE, `cnt`=0, HI=0, LO=0, `hi_n`=`lo_n`=0, busy=0.
  - Mid-RUN, the in-flight result is discarded.

## Timing
- `busy` is decoded from state (RUN), so it is registered.
- Mult-class op with `start` in cycle t:
  - `busy`=1 in cycles t+1..t+MUL_CYCLES.
  - HI/LO show the new value from cycle t+MUL_CYCLES+1, when `busy`=0.
  - A new `start` is accepted in cycle t+MUL_CYCLES+1.
- Div ops: same, using DIV_CYCLES.
- MTHI/MTLO with `start` in cycle t: HI/LO change in t+1. `busy` stays 0.
- HI/LO never change while `busy`=1. No partial updates are visible.
- A and B are sampled only at the start edge. Later changes are ignored.
- Hazard contract (owned by the hazard unit): stall the D-stage MULT/DIV/MF*/MT*/MADD* instruction while `start`|`busy`.

## Configuration
- `MD_SEQ_MADD_EN` defined: MADD (7) and MADDU (8) are decoded, use MUL_CYCLES latency and accumulate into HI/LO.
- `MD_SEQ_MADD_EN` undefined: 7 and 8 are treated as NONE, with no busy and no HI/LO change. No accumulate adder is synthesized.

## Test plan
- Reset, then MULT A=0xFFFFFFFE B=3 at cycle t:
  - `busy`=1 in t+1..t+5.
  - From t+6: HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- MULTU A=0xFFFFFFFE B=3: HI=0x00000002, LO=0xFFFFFFFA after 5 busy cycles.
- DIV A=0xFFFFFFF9 (−7) B=2:
  - `busy` for 10 cycles.
  - Then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - Then DIVU 7/0: 10 busy cycles, HI/LO unchanged.
- MTHI A=0x12345678 during a MULT's busy window → ignored. After the window, MTHI A=0x12345678 → HI=0x12345678 next cycle, `busy` stays 0.
- Assert `reset` in the third busy cycle of a DIV: next cycle `busy`=0, HI=LO=0. No later commit occurs.
- With `MD_SEQ_MADD_EN`:
  - Set HI=0 and LO=5 via MTHI/MTLO.
  - MADD A=2 B=3 → after 5 busy cycles, HI=0, LO=11.
  - Without the macro, the same MADD leaves HI=0, LO=5 and `busy`=0 throughout.
